// File: rtl/icache_dataram_arbiter.sv
// ---------------------------------------------------------------------------
// icache_dataram_arbiter
//
// Purpose
//   Shares the single-port I-cache data array between hit reads (from the
//   MSHR file) and linefill writes (from downstream rxdat). One access is
//   granted per cycle and drives the RAM port combinationally. Read data
//   comes back one cycle after the read enable and is queued in a small
//   in-order response FIFO that the upstream txdat path drains with a
//   valid/ready handshake. Writes have priority. Reads are only accepted
//   while a FIFO slot is guaranteed (read credit), so the FIFO never
//   overflows.
//
// Configuration macro
//   ICACHE_DATARAM_STARVE_GUARD_EN
//     defined   : a starvation counter forces a read through after
//                 STARVE_LIMIT consecutive lost arbitrations.
//     undefined : strict write priority; reads win only when no write is
//                 pending.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   rd_req_vld/rdy                hit-read handshake
//   rd_req_way/index/txnid        read target and upstream transaction id
//   wr_req_vld/rdy                linefill-write handshake
//   wr_req_way/index/data         write target and line data
//   ram_en, ram_we                RAM enable, 1 = write
//   ram_way, ram_index, ram_wdata RAM address and write data (zero when idle)
//   ram_rdata                     RAM read data, valid the cycle after a read
//   rsp_vld/rdy                   read-response handshake
//   rsp_txnid, rsp_data           response FIFO head (zero when empty)
// ---------------------------------------------------------------------------
module icache_dataram_arbiter #(
  parameter int WAY_NUM      = 2,
  parameter int INDEX_WIDTH  = 8,
  parameter int TXNID_WIDTH  = 8,
  parameter int DATA_WIDTH   = 256,
  parameter int RSP_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int WW = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // hit-read request
  input  logic                   rd_req_vld,
  output logic                   rd_req_rdy,
  input  logic [WW-1:0]          rd_req_way,
  input  logic [INDEX_WIDTH-1:0] rd_req_index,
  input  logic [TXNID_WIDTH-1:0] rd_req_txnid,
  // linefill-write request
  input  logic                   wr_req_vld,
  output logic                   wr_req_rdy,
  input  logic [WW-1:0]          wr_req_way,
  input  logic [INDEX_WIDTH-1:0] wr_req_index,
  input  logic [DATA_WIDTH-1:0]  wr_req_data,
  // data RAM port
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [WW-1:0]          ram_way,
  output logic [INDEX_WIDTH-1:0] ram_index,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  // read response
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [TXNID_WIDTH-1:0] rsp_txnid,
  output logic [DATA_WIDTH-1:0]  rsp_data
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [TXNID_WIDTH-1:0] txnid;
    logic [DATA_WIDTH-1:0]  data;
  } rsp_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rsp_t                   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   rd_inflight;
  logic [TXNID_WIDTH-1:0] inflight_txnid;

  // -------------------------------------------------------------------------
  // Handshake / arbitration signals
  // -------------------------------------------------------------------------
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic             rd_cred;
  logic             forced_rd;
  logic             rd_gnt;
  logic             wr_gnt;
  rsp_t             head;

  assign rsp_vld = (fifo_cnt != '0);
  assign pop     = rsp_vld & rsp_rdy;
  assign push    = rd_inflight;

  // Slots that will be occupied after this cycle if no new read is granted.
  // Counting the pop here lets a draining consumer reopen credit in the same
  // cycle, at the cost of a combinational rsp_rdy -> rd_req_rdy path.
  assign occ     = OCC_W'(fifo_cnt) + OCC_W'(rd_inflight) - OCC_W'(pop);
  assign rd_cred = (occ < OCC_W'(RSP_DEPTH));

`ifdef ICACHE_DATARAM_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            rd_blocked;

  // A read that could have gone but lost to a write.
  assign rd_blocked = rd_req_vld & rd_cred & wr_gnt;
  assign forced_rd  = (starve_cnt == SC_W'(STARVE_LIMIT)) & rd_req_vld & rd_cred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_gnt) begin
      starve_cnt <= '0;
    end else if (rd_blocked && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign forced_rd = 1'b0;
`endif

  // Both readies are held low while reset is asserted so no request is
  // accepted (and the RAM is not touched) during reset.
  assign wr_req_rdy = rst_n & ~forced_rd;
  assign rd_req_rdy = rst_n & rd_cred & (~wr_req_vld | forced_rd);

  assign wr_gnt = wr_req_vld & wr_req_rdy;
  assign rd_gnt = rd_req_vld & rd_req_rdy;

  // -------------------------------------------------------------------------
  // RAM port: driven by the winner in the grant cycle, all zero when idle.
  // -------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_way   = '0;
    ram_index = '0;
    ram_wdata = '0;
    if (wr_gnt) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_way   = wr_req_way;
      ram_index = wr_req_index;
      ram_wdata = wr_req_data;
    end else if (rd_gnt) begin
      ram_en    = 1'b1;
      ram_way   = rd_req_way;
      ram_index = rd_req_index;
    end
  end

  // -------------------------------------------------------------------------
  // In-flight read tracking: the RAM returns data one cycle after the grant,
  // and that is the cycle the response is pushed.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight    <= 1'b0;
      inflight_txnid <= '0;
    end else begin
      rd_inflight <= rd_gnt;
      if (rd_gnt) begin
        inflight_txnid <= rd_req_txnid;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array has no reset; an entry is only observed after it
  // has been written, and rsp_* are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{txnid: inflight_txnid, data: ram_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign rsp_txnid = rsp_vld ? head.txnid : '0;
  assign rsp_data  = rsp_vld ? head.data  : '0;

endmodule

// File: tb/tb_icache_dataram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_icache_dataram_arbiter
//
// Directed self-checking bench for icache_dataram_arbiter with default
// parameters. A behavioural single-port RAM (write at the edge, registered
// read data) sits on the RAM port. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// Starvation expectations follow ICACHE_DATARAM_STARVE_GUARD_EN.
// ---------------------------------------------------------------------------
module tb_icache_dataram_arbiter;

  localparam int WW = 1;
  localparam int IW = 8;
  localparam int TW = 8;
  localparam int DW = 256;

  logic          clk;
  logic          rst_n;
  logic          rd_req_vld;
  logic          rd_req_rdy;
  logic [WW-1:0] rd_req_way;
  logic [IW-1:0] rd_req_index;
  logic [TW-1:0] rd_req_txnid;
  logic          wr_req_vld;
  logic          wr_req_rdy;
  logic [WW-1:0] wr_req_way;
  logic [IW-1:0] wr_req_index;
  logic [DW-1:0] wr_req_data;
  logic          ram_en;
  logic          ram_we;
  logic [WW-1:0] ram_way;
  logic [IW-1:0] ram_index;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [TW-1:0] rsp_txnid;
  logic [DW-1:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  icache_dataram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req_vld   (rd_req_vld),
    .rd_req_rdy   (rd_req_rdy),
    .rd_req_way   (rd_req_way),
    .rd_req_index (rd_req_index),
    .rd_req_txnid (rd_req_txnid),
    .wr_req_vld   (wr_req_vld),
    .wr_req_rdy   (wr_req_rdy),
    .wr_req_way   (wr_req_way),
    .wr_req_index (wr_req_index),
    .wr_req_data  (wr_req_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_way      (ram_way),
    .ram_index    (ram_index),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_txnid    (rsp_txnid),
    .rsp_data     (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data RAM.
  logic [DW-1:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_en && ram_we)  mem[{ram_way, ram_index}] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[{ram_way, ram_index}];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [WW-1:0] way, input logic [IW-1:0] idx,
                            input logic [DW-1:0] data);
    wr_req_vld   = 1'b1;
    wr_req_way   = way;
    wr_req_index = idx;
    wr_req_data  = data;
    @(negedge clk);
    check("preload_we", 256'(ram_we), 256'(1'b1));
    tick();
    wr_req_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] line_a5;
    logic [DW-1:0] line_30;
    logic [DW-1:0] line_dead;
    int            k;
    line_a5   = {32{8'hA5}};
    line_30   = {8{32'h1234_5678}};
    line_dead = {8{32'hDEAD_BEEF}};

    // ---------------- reset values, with both requests pending ------------
    rst_n        = 1'b0;
    rd_req_vld   = 1'b1;
    rd_req_way   = '0;
    rd_req_index = 8'h11;
    rd_req_txnid = 8'h01;
    wr_req_vld   = 1'b1;
    wr_req_way   = '0;
    wr_req_index = 8'h11;
    wr_req_data  = line_dead;
    rsp_rdy      = 1'b1;
    @(negedge clk);
    check("rst_rd_rdy", 256'(rd_req_rdy), 256'(1'b0));
    check("rst_wr_rdy", 256'(wr_req_rdy), 256'(1'b0));
    check("rst_ram_en", 256'(ram_en), 256'(1'b0));
    check("rst_ram_we", 256'(ram_we), 256'(1'b0));
    check("rst_ram_index", 256'(ram_index), 256'(0));
    check("rst_ram_wdata", ram_wdata, 256'(0));
    check("rst_rsp_vld", 256'(rsp_vld), 256'(1'b0));
    check("rst_rsp_txnid", 256'(rsp_txnid), 256'(0));
    check("rst_rsp_data", rsp_data, 256'(0));
    tick();
    rd_req_vld = 1'b0;
    wr_req_vld = 1'b0;
    rst_n      = 1'b1;
    tick();

    // ---------------- preload lines through the write port ----------------
    write_line(1'b1, 8'h12, line_a5);
    write_line(1'b1, 8'h30, line_30);
    write_line(1'b0, 8'h50, {32{8'h50}});
    write_line(1'b0, 8'h51, {32{8'h51}});
    write_line(1'b0, 8'h52, {32{8'h52}});

    // ---------------- single read -----------------------------------------
    rd_req_vld   = 1'b1;
    rd_req_way   = 1'b1;
    rd_req_index = 8'h12;
    rd_req_txnid = 8'h05;
    @(negedge clk);
    check("rd1_rdy", 256'(rd_req_rdy), 256'(1'b1));
    check("rd1_ram_en", 256'(ram_en), 256'(1'b1));
    check("rd1_ram_we", 256'(ram_we), 256'(1'b0));
    check("rd1_ram_way", 256'(ram_way), 256'(1'b1));
    check("rd1_ram_index", 256'(ram_index), 256'(8'h12));
    tick();
    rd_req_vld = 1'b0;
    @(negedge clk);
    check("rd1_t1_no_rsp", 256'(rsp_vld), 256'(1'b0));
    check("idle_ram_en", 256'(ram_en), 256'(1'b0));
    check("idle_ram_index", 256'(ram_index), 256'(0));
    tick();
    @(negedge clk);
    check("rd1_t2_rsp_vld", 256'(rsp_vld), 256'(1'b1));
    check("rd1_t2_txnid", 256'(rsp_txnid), 256'(8'h05));
    check("rd1_t2_data", rsp_data, line_a5);
    tick();
    @(negedge clk);
    check("rd1_t3_drained", 256'(rsp_vld), 256'(1'b0));
    tick();

    // ---------------- simultaneous read and write, same line --------------
    rd_req_vld   = 1'b1;
    rd_req_way   = 1'b0;
    rd_req_index = 8'h12;
    rd_req_txnid = 8'h22;
    wr_req_vld   = 1'b1;
    wr_req_way   = 1'b0;
    wr_req_index = 8'h12;
    wr_req_data  = line_dead;
    @(negedge clk);
    check("col_wr_rdy", 256'(wr_req_rdy), 256'(1'b1));
    check("col_rd_rdy", 256'(rd_req_rdy), 256'(1'b0));
    check("col_ram_we", 256'(ram_we), 256'(1'b1));
    check("col_ram_wdata", ram_wdata, line_dead);
    tick();
    wr_req_vld = 1'b0;
    @(negedge clk);
    check("col_rd_rdy_t1", 256'(rd_req_rdy), 256'(1'b1));
    check("col_ram_en_t1", 256'(ram_en), 256'(1'b1));
    check("col_ram_we_t1", 256'(ram_we), 256'(1'b0));
    tick();
    rd_req_vld = 1'b0;
    @(negedge clk);
    check("col_t2_no_rsp", 256'(rsp_vld), 256'(1'b0));
    tick();
    @(negedge clk);
    check("col_rsp_vld", 256'(rsp_vld), 256'(1'b1));
    check("col_rsp_txnid", 256'(rsp_txnid), 256'(8'h22));
    check("col_rsp_data", rsp_data, line_dead);
    tick();

    // ---------------- starvation under continuous writes ------------------
    rd_req_vld   = 1'b1;
    rd_req_way   = 1'b1;
    rd_req_index = 8'h30;
    rd_req_txnid = 8'h33;
    wr_req_vld   = 1'b1;
    wr_req_way   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_req_index = 8'h40 + 8'(i);
      wr_req_data  = {8{32'(i)}};
      @(negedge clk);
      check($sformatf("stv_wr%0d_we", i), 256'(ram_we), 256'(1'b1));
      check($sformatf("stv_wr%0d_rd_rdy", i), 256'(rd_req_rdy), 256'(1'b0));
      tick();
    end
    wr_req_index = 8'h44;
`ifdef ICACHE_DATARAM_STARVE_GUARD_EN
    @(negedge clk);
    check("stv_forced_rd_rdy", 256'(rd_req_rdy), 256'(1'b1));
    check("stv_forced_wr_rdy", 256'(wr_req_rdy), 256'(1'b0));
    check("stv_forced_we", 256'(ram_we), 256'(1'b0));
    check("stv_forced_index", 256'(ram_index), 256'(8'h30));
    tick();
    // Counter must be back at zero: the next read loses to the write again.
    rd_req_txnid = 8'h34;
    @(negedge clk);
    check("stv_cleared_we", 256'(ram_we), 256'(1'b1));
    check("stv_cleared_rd_rdy", 256'(rd_req_rdy), 256'(1'b0));
    tick();
    rd_req_vld = 1'b0;
    wr_req_vld = 1'b0;
`else
    @(negedge clk);
    check("stv_strict_rd_rdy", 256'(rd_req_rdy), 256'(1'b0));
    check("stv_strict_we", 256'(ram_we), 256'(1'b1));
    tick();
    wr_req_vld = 1'b0;
    @(negedge clk);
    check("stv_release_rd_rdy", 256'(rd_req_rdy), 256'(1'b1));
    check("stv_release_we", 256'(ram_we), 256'(1'b0));
    tick();
    rd_req_vld = 1'b0;
`endif
    k = 0;
    @(negedge clk);
    while (!rsp_vld && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("stv_rsp_seen", 256'(rsp_vld), 256'(1'b1));
    check("stv_rsp_txnid", 256'(rsp_txnid), 256'(8'h33));
    check("stv_rsp_data", rsp_data, line_30);
    tick();
    tick();

    // ---------------- backpressure: credit limit and in-order drain -------
    rsp_rdy      = 1'b0;
    rd_req_vld   = 1'b1;
    rd_req_way   = 1'b0;
    rd_req_index = 8'h50;
    rd_req_txnid = 8'h40;
    @(negedge clk);
    check("bp_rd0_rdy", 256'(rd_req_rdy), 256'(1'b1));
    tick();
    rd_req_index = 8'h51;
    rd_req_txnid = 8'h41;
    @(negedge clk);
    check("bp_rd1_rdy", 256'(rd_req_rdy), 256'(1'b1));
    tick();
    rd_req_index = 8'h52;
    rd_req_txnid = 8'h42;
    @(negedge clk);
    check("bp_rd2_blocked", 256'(rd_req_rdy), 256'(1'b0));
    check("bp_rd2_ram_en", 256'(ram_en), 256'(1'b0));
    tick();
    @(negedge clk);
    check("bp_full_blocked", 256'(rd_req_rdy), 256'(1'b0));
    check("bp_head_vld", 256'(rsp_vld), 256'(1'b1));
    check("bp_head_txnid", 256'(rsp_txnid), 256'(8'h40));
    tick();
    @(negedge clk);
    check("bp_hold_txnid", 256'(rsp_txnid), 256'(8'h40));
    check("bp_hold_data", rsp_data, {32{8'h50}});
    check("bp_hold_blocked", 256'(rd_req_rdy), 256'(1'b0));
    #1;
    rsp_rdy = 1'b1;
    #1;
    check("bp_reopen_rdy", 256'(rd_req_rdy), 256'(1'b1));
    tick();
    rd_req_vld = 1'b0;
    @(negedge clk);
    check("bp_drain1_txnid", 256'(rsp_txnid), 256'(8'h41));
    check("bp_drain1_data", rsp_data, {32{8'h51}});
    tick();
    @(negedge clk);
    check("bp_drain2_vld", 256'(rsp_vld), 256'(1'b1));
    check("bp_drain2_txnid", 256'(rsp_txnid), 256'(8'h42));
    check("bp_drain2_data", rsp_data, {32{8'h52}});
    tick();
    @(negedge clk);
    check("bp_empty", 256'(rsp_vld), 256'(1'b0));
    tick();

    // ---------------- reset one cycle after a read grant ------------------
    rd_req_vld   = 1'b1;
    rd_req_way   = 1'b1;
    rd_req_index = 8'h12;
    rd_req_txnid = 8'h77;
    @(negedge clk);
    check("rr_grant_rdy", 256'(rd_req_rdy), 256'(1'b1));
    tick();
    rd_req_vld = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    check("rr_in_rst_rd_rdy", 256'(rd_req_rdy), 256'(1'b0));
    check("rr_in_rst_wr_rdy", 256'(wr_req_rdy), 256'(1'b0));
    check("rr_in_rst_rsp_vld", 256'(rsp_vld), 256'(1'b0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rr_no_rsp%0d", i), 256'(rsp_vld), 256'(1'b0));
      tick();
    end
    rd_req_vld   = 1'b1;
    rd_req_txnid = 8'h78;
    @(negedge clk);
    check("rr_post_rd_rdy", 256'(rd_req_rdy), 256'(1'b1));
    tick();
    rd_req_vld = 1'b0;
    tick();
    @(negedge clk);
    check("rr_post_rsp_vld", 256'(rsp_vld), 256'(1'b1));
    check("rr_post_rsp_txnid", 256'(rsp_txnid), 256'(8'h78));
    check("rr_post_rsp_data", rsp_data, line_a5);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
